// File: rtl/demod_pkg.sv
// Shared constants and tag type for the demodulation-segment datapath and its
// request arbiter.
package demod_pkg;

    localparam int DATA_W      = 32;
    localparam int SEG_COUNT   = 10;
    localparam int PIPE_LAT    = 3;
    localparam int NUM_REQ_MAX = 4;
    localparam int ID_W        = $clog2(NUM_REQ_MAX);

    // Travels alongside a word through the datapath to mark ownership.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } demod_tag_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr_i and wraps; the grant is
// suppressed (but the winner index still reported) when en_i is low.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o
);

    always_comb begin : arb
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found = 1'b1;
                idx_o = PTR_W'(j);
            end
        end
        if (found && en_i) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/demod_segment_arbiter.sv
// Round-robin front end sharing one fixed-latency demodulation datapath between
// NUM_REQ producers, with a tag pipeline that identifies who owns each output.
module demod_segment_arbiter #(
    parameter  int NUM_REQ  = 2,
    parameter  int DATA_W   = demod_pkg::DATA_W,
    parameter  int PIPE_LAT = demod_pkg::PIPE_LAT,
    parameter  int CNT_W    = 16,
    localparam int RID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      hold,
    output logic [DATA_W-1:0]         dp_input_bit,
    output logic                      rsp_valid,
    output logic [RID_W-1:0]          rsp_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          accept_cnt
);
    import demod_pkg::*;

    logic [RID_W-1:0]    ptr_q, ptr_d, win;
    logic [NUM_REQ-1:0]  gnt;
    logic                issue;
    logic [DATA_W-1:0]   dp_q, dp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    demod_tag_t          tag_in;
    // Stage 0 lines up with the datapath input register; the last stage lines
    // up with the segment outputs PIPE_LAT cycles later.
    demod_tag_t [PIPE_LAT:0] tag_q;

    // Gating with reset keeps ready low for the whole async-reset window.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (~hold & reset),
        .gnt_o (gnt),
        .idx_o (win)
    );

    assign req_ready = gnt;
    assign issue     = |gnt;

    always_comb begin
        ptr_d  = ptr_q;
        dp_d   = dp_q;
        cnt_d  = cnt_q;
        tag_in = '0;
        if (issue) begin
            ptr_d        = RID_W'(rr_next(int'(win), NUM_REQ));
            dp_d         = req_data[win*DATA_W +: DATA_W];
            cnt_d        = cnt_q + 1'b1;
            tag_in.valid = 1'b1;
            tag_in.id    = ID_W'(win);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            dp_q  <= '0;
            cnt_q <= '0;
            tag_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            dp_q  <= dp_d;
            cnt_q <= cnt_d;
            tag_q <= {tag_q[PIPE_LAT-1:0], tag_in};
        end
    end

    always_comb begin
        busy = |req_valid;
        for (int s = 0; s <= PIPE_LAT; s++) busy = busy | tag_q[s].valid;
    end

    assign dp_input_bit = dp_q;
    assign accept_cnt   = cnt_q;
    assign rsp_valid    = tag_q[PIPE_LAT].valid;
    assign rsp_id       = RID_W'(tag_q[PIPE_LAT].id);

endmodule

// File: tb/tb_demod_segment_arbiter.sv
// Bench for demod_segment_arbiter: directed table, hand sequences for reset and
// wrap corners, and random traffic against an issue-history reference model.
module tb_demod_segment_arbiter;
  localparam int N = 4, DW = 32, LAT = 3, CW = 16;

  typedef struct {
    logic [N-1:0] vld;
    logic         hold;
    logic [N-1:0] rdy;
    logic         rv;
    logic [1:0]   rid;
  } vec_t;

  logic            clk = 1'b0, reset = 1'b0, hold = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [DW-1:0]   dp_input_bit;
  logic            rsp_valid, busy;
  logic [1:0]      rsp_id;
  logic [CW-1:0]   accept_cnt;

  int checks = 0, errors = 0;

  // reference model: pointer, count, last issued word, per-edge issue history
  int           m_ptr = 0;
  int unsigned  m_cnt = 0;
  logic [DW-1:0] m_dp = '0;
  logic [N-1:0] m_gnt = '0, pend = '0;
  int           hist[$];
  vec_t         tbl[20];

  demod_segment_arbiter #(.NUM_REQ(N), .DATA_W(DW), .PIPE_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .hold(hold), .dp_input_bit(dp_input_bit),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .busy(busy), .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] v, input logic h, input logic [N-1:0] r,
                              input logic rv, input logic [1:0] rid);
    vec_t t;
    t.vld = v; t.hold = h; t.rdy = r; t.rv = rv; t.rid = rid;
    return t;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_dp = '0; m_gnt = '0; pend = '0;
    hist.delete();
  endtask

  // one clock: check comb outputs before the edge, registered ones after it
  task automatic step();
    int w, old;
    bit iss, bz;
    #1;
    if ((pend & ~req_valid) != '0) begin
      errors++;
      $display("FAIL protocol: word retracted without handshake, valid=%b pending=%b", req_valid, pend);
    end
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    iss = (w >= 0) && !hold;
    m_gnt = '0;
    if (iss) m_gnt[w] = 1'b1;
    bz = (req_valid != '0);
    foreach (hist[i]) if (hist[i] >= 0) bz = 1'b1;
    chk("req_ready", req_ready, m_gnt);
    chk("busy", busy, bz);
    pend = req_valid & ~m_gnt;
    @(posedge clk);
    if (iss) begin
      m_dp  = req_data[w*DW +: DW];
      m_ptr = (w + 1) % N;
      m_cnt++;
    end
    hist.push_back(iss ? w : -1);
    if (hist.size() > LAT + 1) void'(hist.pop_front());
    #1;
    old = (hist.size() == LAT + 1) ? hist[0] : -1;
    chk("dp_input_bit", dp_input_bit, m_dp);
    chk("rsp_valid", rsp_valid, old >= 0);
    chk("rsp_id", rsp_id, (old >= 0) ? old : 0);
    chk("accept_cnt", accept_cnt, m_cnt % 65536);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    model_reset();
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(4'b0011, 0, 4'b0001, 0, 0);
    tbl[1]  = mk(4'b0011, 0, 4'b0010, 0, 0);
    tbl[2]  = mk(4'b0011, 0, 4'b0001, 0, 0);
    tbl[3]  = mk(4'b0011, 0, 4'b0010, 1, 0);
    tbl[4]  = mk(4'b0011, 0, 4'b0001, 1, 1);
    tbl[5]  = mk(4'b0011, 0, 4'b0010, 1, 0);
    tbl[6]  = mk(4'b0001, 0, 4'b0001, 1, 1);
    tbl[7]  = mk(4'b0000, 0, 4'b0000, 1, 0);
    tbl[8]  = mk(4'b0010, 0, 4'b0010, 1, 1);
    tbl[9]  = mk(4'b0010, 0, 4'b0010, 1, 0);
    tbl[10] = mk(4'b0010, 0, 4'b0010, 0, 0);
    tbl[11] = mk(4'b0010, 1, 4'b0000, 1, 1);
    tbl[12] = mk(4'b0010, 1, 4'b0000, 1, 1);
    tbl[13] = mk(4'b0010, 1, 4'b0000, 1, 1);
    tbl[14] = mk(4'b0010, 1, 4'b0000, 0, 0);
    tbl[15] = mk(4'b0010, 0, 4'b0010, 0, 0);
    tbl[16] = mk(4'b0000, 0, 4'b0000, 0, 0);
    tbl[17] = mk(4'b0000, 0, 4'b0000, 0, 0);
    tbl[18] = mk(4'b0000, 0, 4'b0000, 1, 1);
    tbl[19] = mk(4'b0000, 0, 4'b0000, 0, 0);

    // reset state, with a requester already waiting
    model_reset();
    repeat (2) @(posedge clk);
    #1 req_valid = 4'b0001;
    #1;
    chk("rst req_ready", req_ready, 0);
    chk("rst dp", dp_input_bit, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_id", rsp_id, 0);
    chk("rst accept_cnt", accept_cnt, 0);
    chk("rst busy", busy, 1);
    req_valid = '0;
    @(negedge clk) reset = 1'b1;

    // single issue
    req_data[DW-1:0] = 32'hA5A5_0001;
    req_valid = 4'b0001;
    #1 chk("t1 ready", req_ready, 4'b0001);
    step();
    chk("t1 dp", dp_input_bit, 32'hA5A5_0001);
    chk("t1 cnt", accept_cnt, 1);
    req_valid = '0;
    step(); step();
    chk("t1 rsp early", rsp_valid, 0);
    step();
    chk("t1 rsp", rsp_valid, 1);
    chk("t1 rsp_id", rsp_id, 0);
    step();
    chk("t1 rsp end", rsp_valid, 0);
    chk("t1 busy", busy, 0);

    // contention then hold, from pointer 0
    do_reset();
    for (int r = 0; r < 20; r++) begin
      req_valid = tbl[r].vld;
      hold = tbl[r].hold;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
      #1 chk($sformatf("tbl%0d ready", r), req_ready, tbl[r].rdy);
      step();
      chk($sformatf("tbl%0d rsp_valid", r), rsp_valid, tbl[r].rv);
      chk($sformatf("tbl%0d rsp_id", r), rsp_id, tbl[r].rid);
    end
    hold = 1'b0;

    // async reset with two words in flight
    do_reset();
    req_data[DW-1:0] = 32'h1111_0000;
    req_data[DW +: DW] = 32'h2222_0000;
    req_valid = 4'b0001; step();
    req_valid = 4'b0011; step();
    chk("t4 dp before", dp_input_bit, 32'h2222_0000);
    #2 reset = 1'b0;
    #1;
    chk("t4 dp", dp_input_bit, 0);
    chk("t4 cnt", accept_cnt, 0);
    chk("t4 rsp_valid", rsp_valid, 0);
    chk("t4 ready", req_ready, 0);
    model_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 chk("t4 rsp in reset", rsp_valid, 0);
    end
    req_valid = '0;
    @(negedge clk) reset = 1'b1;
    repeat (5) step();

    // pointer wrap 3 -> 0 -> 1
    do_reset();
    req_valid = 4'b0100; step();
    req_valid = 4'b1001;
    #1 chk("t5 first", req_ready, 4'b1000);
    step();
    req_valid = 4'b0001;
    #1 chk("t5 second", req_ready, 4'b0001);
    step();
    req_valid = 4'b0011;
    #1 chk("t5 ptr1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0001; step();
    req_valid = '0; repeat (4) step();

    // counter wrap
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 65535; c++) begin
      req_data[DW-1:0] = c;
      step();
    end
    chk("t6 pre", accept_cnt, 16'hFFFF);
    step();
    chk("t6 wrap", accept_cnt, 0);
    req_valid = '0;
    repeat (4) step();

    // random traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || m_gnt[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_data[i*DW +: DW] = $urandom;
        end
      hold = ($urandom_range(0, 7) == 0);
      step();
    end
    hold = 1'b0;
    // let any pending words go before idling
    for (int c = 0; c < 8 && req_valid != '0; c++) begin
      for (int i = 0; i < N; i++) if (m_gnt[i]) req_valid[i] = 1'b0;
      step();
    end
    for (int i = 0; i < N; i++) if (m_gnt[i]) req_valid[i] = 1'b0;
    if (req_valid != '0) begin
      errors++;
      $display("FAIL drain: requests still pending %b", req_valid);
    end
    req_valid = '0;
    repeat (LAT + 2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
